// File: rtl/spi_reg_target_pkg.sv
// Shared FSM states, transaction width codes and width helpers for the SPI register target.
package spi_reg_target_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WDATA,
    S_TURN,
    S_RDATA,
    S_DONE
  } state_t;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;
  localparam logic [1:0] W_NONE = 2'b11;

  function automatic logic [5:0] width_bits(input logic [1:0] w);
    case (w)
      W_BYTE:  return 6'd8;
      W_HALF:  return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  function automatic logic [31:0] width_mask(input logic [1:0] w);
    case (w)
      W_BYTE:  return 32'h0000_00FF;
      W_HALF:  return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// Registers the pre-synchronized SPI clock once and flags its rising/falling edges for one clk.
module spi_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_clk,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= spi_clk;
  end

  assign rise = spi_clk & ~prev;
  assign fall = ~spi_clk & prev;

endmodule

// File: rtl/spi_reg_target.sv
// SPI mode-0 register target: decodes clk-oversampled frames onto a peripheral register bus.
// Header/write results commit one clk after the final rise; reads answer with zeros if data misses turnaround.
module spi_reg_target
  import spi_reg_target_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int REG_W     = 32,
  parameter int TURN_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_rw,
  output logic [1:0]        txn_width,
  output logic              reg_addr_v,
  input  logic [REG_W-1:0]  reg_data_i,
  input  logic              reg_data_i_dv,
  output logic [REG_W-1:0]  reg_data_o,
  output logic              reg_data_o_dv,
  output logic              rd_late
);

  localparam int HDR_BITS = 3 + ADDR_W;
  localparam int SR_W     = (HDR_BITS > REG_W) ? HDR_BITS : REG_W;
  localparam int CNT_W    = 6;

  logic rise, fall;

  spi_edge_detect u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .spi_clk (spi_clk),
    .rise    (rise),
    .fall    (fall)
  );

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [SR_W-2:0]    sr;
  logic [SR_W-1:0]    sr_in;
  logic [REG_W-1:0]   rd_buf, osr;
  logic               rd_have, armed;
  logic               start, hdr_last, wr_last, turn_load, abort;
  logic [1:0]         hdr_w;
  logic [5:0]         n_bits;

  assign sr_in  = {sr, spi_mosi};
  assign hdr_w  = sr_in[HDR_BITS-2 -: 2];
  assign n_bits = width_bits(txn_width);
  assign abort  = spi_cs_n && (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    hdr_last  = 1'b0;
    wr_last   = 1'b0;
    turn_load = 1'b0;
    if (!ena || abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (!spi_cs_n && armed) begin
          start     = 1'b1;
          state_nxt = S_HDR;
        end
        S_HDR: if (rise && cnt == CNT_W'(HDR_BITS - 1)) begin
          hdr_last = 1'b1;
          if (hdr_w == W_NONE)        state_nxt = S_DONE;
          else if (sr_in[HDR_BITS-1]) state_nxt = S_WDATA;
          else                        state_nxt = S_TURN;
        end
        S_WDATA: if (rise && cnt == n_bits - 6'd1) begin
          wr_last   = 1'b1;
          state_nxt = S_DONE;
        end
        S_TURN: if (fall && cnt == CNT_W'(TURN_BITS)) begin
          turn_load = 1'b1;
          state_nxt = S_RDATA;
        end
        S_RDATA: if (rise && cnt == n_bits - 6'd1) state_nxt = S_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      sr            <= '0;
      rd_buf        <= '0;
      osr           <= '0;
      rd_have       <= 1'b0;
      armed         <= 1'b0;
      reg_addr      <= '0;
      reg_rw        <= 1'b0;
      txn_width     <= W_BYTE;
      reg_addr_v    <= 1'b0;
      reg_data_o    <= '0;
      reg_data_o_dv <= 1'b0;
      rd_late       <= 1'b0;
    end else begin
      reg_data_o_dv <= 1'b0;
      rd_late       <= 1'b0;
      // A frame already in flight when reset released is skipped until cs_n is seen high.
      if (spi_cs_n) armed <= 1'b1;
      if (rise) begin
        cnt <= cnt + 1'b1;
        sr  <= sr_in[SR_W-2:0];
      end
      if (start) begin
        cnt     <= '0;
        sr      <= '0;
        rd_have <= 1'b0;
      end
      if (hdr_last) begin
        cnt <= '0;
        sr  <= '0;
        if (hdr_w != W_NONE) begin
          reg_rw     <= sr_in[HDR_BITS-1];
          txn_width  <= hdr_w;
          reg_addr   <= sr_in[ADDR_W-1:0];
          reg_addr_v <= ~sr_in[HDR_BITS-1];
        end
      end
      if (wr_last) begin
        reg_data_o    <= sr_in[REG_W-1:0] & width_mask(txn_width);
        reg_data_o_dv <= 1'b1;
      end
      if (turn_load) begin
        cnt <= '0;
        if (rd_have) begin
          osr <= rd_buf << (6'(REG_W) - n_bits);
        end else begin
          osr        <= '0;
          rd_late    <= 1'b1;
          reg_addr_v <= 1'b0;
        end
      end
      if (state == S_RDATA && fall) osr <= {osr[REG_W-2:0], 1'b0};
      if (reg_addr_v && reg_data_i_dv) begin
        rd_buf     <= reg_data_i & width_mask(txn_width);
        rd_have    <= 1'b1;
        reg_addr_v <= 1'b0;
      end
      if (abort || !ena) reg_addr_v <= 1'b0;
    end
  end

  assign spi_miso = (state == S_RDATA) & osr[REG_W-1];

endmodule

// File: tb/tb_spi_reg_target.sv
// Directed bench for spi_reg_target: acts as SPI master at clk/8 and as the peripheral read responder.
module tb_spi_reg_target;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        spi_cs_n = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [5:0]  reg_addr;
  logic        reg_rw;
  logic [1:0]  txn_width;
  logic        reg_addr_v;
  logic [31:0] reg_data_i = '0;
  logic        reg_data_i_dv = 1'b0;
  logic [31:0] reg_data_o;
  logic        reg_data_o_dv;
  logic        rd_late;

  spi_reg_target #(.ADDR_W(6), .REG_W(32), .TURN_BITS(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .spi_cs_n      (spi_cs_n),
    .spi_clk       (spi_clk),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .reg_addr      (reg_addr),
    .reg_rw        (reg_rw),
    .txn_width     (txn_width),
    .reg_addr_v    (reg_addr_v),
    .reg_data_i    (reg_data_i),
    .reg_data_i_dv (reg_data_i_dv),
    .reg_data_o    (reg_data_o),
    .reg_data_o_dv (reg_data_o_dv),
    .rd_late       (rd_late)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the committed register-bus view, advanced at frame level by the master tasks.
  logic [5:0]  m_addr = '0;
  logic        m_rw = 1'b0;
  logic [1:0]  m_width = 2'b00;
  logic [31:0] m_data_o = '0;
  int          dv_cyc = -1;
  int          late_cyc = -1;
  bit          m_en = 1'b0;
  bit          m_rd_phase = 1'b0;
  int          dv_count = 0;
  int          late_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] fit(input logic [31:0] d, input int n);
    return (n >= 32) ? d : (d & ((32'd1 << n) - 32'd1));
  endfunction

  function automatic int data_len(input logic [1:0] w);
    return (w == 2'b11) ? 8 : (8 << w);
  endfunction

  always @(negedge clk) begin
    if (m_en && rst_n) begin
      check("reg_addr", 32'(reg_addr), 32'(m_addr));
      check("reg_rw", 32'(reg_rw), 32'(m_rw));
      check("txn_width", 32'(txn_width), 32'(m_width));
      check("reg_data_o", reg_data_o, m_data_o);
      check("reg_data_o_dv", 32'(reg_data_o_dv), 32'(cyc == dv_cyc));
      check("rd_late", 32'(rd_late), 32'(cyc == late_cyc));
      if (!m_rd_phase) check("miso_idle", 32'(spi_miso), 32'd0);
      if (reg_data_o_dv) dv_count++;
      if (rd_late) late_count++;
    end
  end

  task automatic spi_rise(input logic b, output logic so);
    spi_mosi = b;
    repeat (3) @(posedge clk);
    #1;
    spi_clk = 1'b1;
    so = spi_miso;
    @(posedge clk);
    #1;
  endtask

  task automatic spi_fall();
    repeat (3) @(posedge clk);
    #1;
    spi_clk = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    spi_cs_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic end_frame();
    repeat (3) @(posedge clk);
    #1;
    spi_cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_header(input logic rw, input logic [1:0] w, input logic [5:0] a);
    logic [8:0] h;
    logic so;
    h = {rw, w, a};
    for (int i = 8; i >= 0; i--) begin
      spi_rise(h[i], so);
      if (i == 0 && w != 2'b11) begin
        m_addr  = a;
        m_rw    = rw;
        m_width = w;
      end
      spi_fall();
    end
  endtask

  task automatic write_data(input logic [31:0] d, input int n, input int nsend, input bit commit);
    logic so;
    for (int i = 0; i < nsend; i++) begin
      spi_rise(d[n-1-i], so);
      if (i == n - 1 && commit) begin
        m_data_o = fit(d, n);
        dv_cyc   = cyc;
      end
      spi_fall();
    end
  endtask

  task automatic write_txn(input logic [1:0] w, input logic [5:0] a, input logic [31:0] d, input int nsend);
    int n;
    n = data_len(w);
    start_frame();
    send_header(1'b1, w, a);
    write_data(d, n, nsend, (w != 2'b11) && (nsend == n));
    end_frame();
  endtask

  task automatic read_data(input int n, input bit late, output logic [31:0] got);
    logic so;
    got = '0;
    for (int i = 0; i < 8; i++) begin
      spi_rise(1'b0, so);
      check("miso_turn", 32'(so), 32'd0);
      spi_fall();
    end
    if (late) late_cyc = cyc;
    m_rd_phase = 1'b1;
    for (int i = 0; i < n; i++) begin
      spi_rise(1'b0, so);
      got = {got[30:0], so};
      if (i == n - 1) m_rd_phase = 1'b0;
      spi_fall();
    end
  endtask

  task automatic read_txn(input logic [1:0] w, input logic [5:0] a, input logic [31:0] rsp,
                          input bit respond, input logic [31:0] lit);
    logic [31:0] got;
    logic [31:0] expw;
    int n;
    n = data_len(w);
    expw = respond ? fit(rsp, n) : 32'd0;
    start_frame();
    fork
      begin
        send_header(1'b0, w, a);
        read_data(n, !respond, got);
      end
      begin
        int k;
        k = 0;
        while (reg_addr_v !== 1'b1 && k < 300) begin
          @(posedge clk);
          #1;
          k++;
        end
        check("addr_v_rise", 32'(reg_addr_v), 32'd1);
        if (respond) begin
          repeat (3) @(posedge clk);
          #1;
          reg_data_i    = rsp;
          reg_data_i_dv = 1'b1;
          check("addr_v_hold", 32'(reg_addr_v), 32'd1);
          @(posedge clk);
          #1;
          reg_data_i_dv = 1'b0;
          reg_data_i    = '0;
          check("addr_v_drop", 32'(reg_addr_v), 32'd0);
        end
      end
    join
    check("miso_word", got, expw);
    check("miso_literal", got, lit);
    check("addr_v_end", 32'(reg_addr_v), 32'd0);
    end_frame();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, 32'(reg_addr), 32'd0);
    check({tag, "_rw"}, 32'(reg_rw), 32'd0);
    check({tag, "_width"}, 32'(txn_width), 32'd0);
    check({tag, "_addr_v"}, 32'(reg_addr_v), 32'd0);
    check({tag, "_data_o"}, reg_data_o, 32'd0);
    check({tag, "_dv"}, 32'(reg_data_o_dv), 32'd0);
    check({tag, "_late"}, 32'(rd_late), 32'd0);
    check({tag, "_miso"}, 32'(spi_miso), 32'd0);
  endtask

  initial begin
    logic so;
    int dv0;
    int late0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    rst_n = 1'b1;
    m_en  = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    dv0 = dv_count;
    write_txn(2'b10, 6'd5, 32'hDEADBEEF, 32);
    check("w1_addr", 32'(reg_addr), 32'd5);
    check("w1_rw", 32'(reg_rw), 32'd1);
    check("w1_width", 32'(txn_width), 32'd2);
    check("w1_data", reg_data_o, 32'hDEADBEEF);
    check("w1_strobes", 32'(dv_count - dv0), 32'd1);

    dv0 = dv_count;
    write_txn(2'b00, 6'd63, 32'h000000A5, 8);
    check("w2_addr", 32'(reg_addr), 32'd63);
    check("w2_data", reg_data_o, 32'h000000A5);
    check("w2_strobes", 32'(dv_count - dv0), 32'd1);

    read_txn(2'b10, 6'd10, 32'h12345678, 1'b1, 32'h12345678);
    check("r1_addr", 32'(reg_addr), 32'd10);
    check("r1_rw", 32'(reg_rw), 32'd0);

    late0 = late_count;
    read_txn(2'b10, 6'd17, 32'h0, 1'b0, 32'h0);
    check("late_pulses", 32'(late_count - late0), 32'd1);

    dv0 = dv_count;
    write_txn(2'b10, 6'd7, 32'hFFFFFFFF, 5);
    check("abort_strobes", 32'(dv_count - dv0), 32'd0);
    check("abort_data", reg_data_o, 32'h000000A5);
    check("abort_addr", 32'(reg_addr), 32'd7);

    dv0 = dv_count;
    write_txn(2'b01, 6'd9, 32'h0000F00D, 16);
    check("post_abort_addr", 32'(reg_addr), 32'd9);
    check("post_abort_data", reg_data_o, 32'h0000F00D);
    check("post_abort_strobes", 32'(dv_count - dv0), 32'd1);

    dv0 = dv_count;
    write_txn(2'b11, 6'd1, 32'h0000005A, 8);
    check("inval_addr", 32'(reg_addr), 32'd9);
    check("inval_width", 32'(txn_width), 32'd1);
    check("inval_data", reg_data_o, 32'h0000F00D);
    check("inval_strobes", 32'(dv_count - dv0), 32'd0);

    start_frame();
    send_header(1'b0, 2'b00, 6'd21);
    for (int i = 0; i < 3; i++) begin
      spi_rise(1'b0, so);
      spi_fall();
    end
    check("rm_addr_v_pre", 32'(reg_addr_v), 32'd1);
    check("rm_addr_pre", 32'(reg_addr), 32'd21);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    m_addr   = '0;
    m_rw     = 1'b0;
    m_width  = 2'b00;
    m_data_o = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      spi_rise(i[0], so);
      spi_fall();
    end
    check("stale_addr_v", 32'(reg_addr_v), 32'd0);
    check("stale_addr", 32'(reg_addr), 32'd0);
    end_frame();

    dv0 = dv_count;
    write_txn(2'b00, 6'd2, 32'h0000003C, 8);
    check("rec_addr", 32'(reg_addr), 32'd2);
    check("rec_data", reg_data_o, 32'h0000003C);
    check("rec_strobes", 32'(dv_count - dv0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_target.md
Name: spi_reg_target

Overview:
- SPI mode-0 register-access target that sits directly upstream of a TinyQV peripheral in the test harness.
- Decodes SPI frames, already synchronized into `clk`, into the peripheral register bus:
  - address plus address-valid;
  - write data plus data-valid;
  - read/write flag;
  - transaction width.
- Returns read data on MISO.
- Everything is oversampled in the `clk` domain; there is no logic on `spi_clk`.

Parameters:
- ADDR_W, 6: register address width.
- REG_W, 32: register data width; must be 32 (byte/half/word widths are fixed).
- TURN_BITS, 8: dummy SPI clocks between read header and read data.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  block enable; when low, SPI edges are ignored and the FSM is held in IDLE
- spi_cs_n  in  1  chip select, active low, pre-synchronized
- spi_clk  in  1  SPI clock, pre-synchronized
- spi_mosi  in  1  SPI data in, pre-synchronized
- spi_miso  out  1  SPI data out
- reg_addr  out  ADDR_W  decoded register address
- reg_rw  out  1  1 = write, 0 = read
- txn_width  out  2  00 byte, 01 half, 10 word; 11 is never presented valid
- reg_addr_v  out  1  read request; high until read data is accepted
- reg_data_i  in  REG_W  read data from the peripheral
- reg_data_i_dv  in  1  read data valid
- reg_data_o  out  REG_W  write data, zero-extended
- reg_data_o_dv  out  1  one-cycle write strobe
- rd_late  out  1  one-cycle pulse: read data arrived after turnaround ended

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0 and the FSM is in IDLE.
- Edge detection:
  - `spi_clk` is registered once.
  - rise = spi_clk & ~prev; fall = ~spi_clk & prev.
  - MOSI is sampled on rise; MISO changes on fall.
- Frame format, MSB first: rw(1), width(2), addr(ADDR_W); then the data phase.
- Data length N = 8 << width, i.e. 8, 16 or 32 bits.
- FSM states: IDLE, HDR, WDATA, TURN, RDATA, DONE.
  - IDLE → HDR on cs_n low. Bit counter cleared. Shift register cleared.
  - HDR: one bit per rise. After bit 3+ADDR_W:
    - reg_addr, reg_rw and txn_width are updated the next cycle.
    - width 11 → DONE, with no strobes and no address latch.
    - rw=1 → WDATA.
    - rw=0 → TURN, and reg_addr_v is set the next cycle.
  - WDATA: shift N bits. On the rise of bit N:
    - next cycle, reg_data_o = zero-extended data;
    - reg_data_o_dv pulses for exactly 1 cycle;
    - go to DONE.
  - TURN: count TURN_BITS rises. MISO = 0 throughout.
    - On the fall following the last turnaround rise, load the out-shifter with the captured data, placing bit N-1 in the MSB.
    - Go to RDATA.
    - If no data has been captured by then: load 0, pulse rd_late, and drop reg_addr_v.
  - RDATA: each fall shifts the next bit onto MISO. After N rises → DONE.
  - DONE: ignore spi_clk and hold MISO at 0 until cs_n goes high → IDLE.
- Read capture:
  - While reg_addr_v && reg_data_i_dv, latch reg_data_i[N-1:0] and clear reg_addr_v the next cycle.
  - Capture is allowed in the same cycle reg_addr_v is first set.
  - If reg_data_i_dv is high while reg_addr_v is low, it is ignored.
- Abort: cs_n high in any state other than IDLE → IDLE next cycle.
  - reg_addr_v cleared.
  - No reg_data_o_dv.
  - reg_data_o, reg_addr, reg_rw and txn_width keep their last committed values.
- Output stability: reg_addr, reg_rw, txn_width and reg_data_o hold until the next header or write completes.
- rise and fall in the same clk cycle cannot occur.
- A cs_n high and an SPI edge in the same cycle: the abort wins.
- rst_n asserted mid-frame: immediate return to the reset state. A frame continuing after reset is ignored until cs_n cycles high.

Decomposition:
- Package spi_reg_target_pkg holds:
  - the state enum;
  - width codes W_BYTE=2'b00, W_HALF=2'b01, W_WORD=2'b10, W_NONE=2'b11;
  - a function width_bits(w) returning 8, 16 or 32.
- One sub-module, spi_edge_detect: registers `spi_clk` and produces the rise/fall pulses.

Test Plan:
- Word write of header 1,10,000101 plus 0xDEADBEEF at spi_clk = clk/8:
  - reg_addr=5, reg_rw=1, txn_width=2, reg_data_o=0xDEADBEEF;
  - reg_data_o_dv high exactly 1 cycle.
- Byte write of header 1,00,111111 plus 0xA5: reg_addr=63, reg_data_o=0x000000A5, one strobe.
- Word read of header 0,10,001010, with the bench returning reg_data_i_dv 3 cycles after reg_addr_v rises with 0x12345678:
  - after 8 turnaround clocks, MISO shifts out 0x12345678 MSB first;
  - reg_addr_v falls the cycle after capture.
- Late read, with reg_data_i_dv never asserted: MISO is 0 for all 32 bits and rd_late pulses once at the end of turnaround.
- Abort: cs_n high after 5 write data bits gives no reg_data_o_dv and reg_data_o unchanged. The next full frame then decodes correctly.
- Invalid width header 1,11,000001 plus 8 data bits: no strobes and reg_addr not updated. Separately, rst_n pulsed mid-read clears all outputs to 0 asynchronously.
